// File: rtl/dice_roll_engine.sv
// -----------------------------------------------------------------------------
// dice_roll_engine
//
// Multi-channel dice roller. A shared prescaler produces a one-cycle roll tick
// every TICK_DIV clocks. Each channel has its own free-running 16-bit LFSR and
// a small FSM (IDLE / ROLLING / HELD / LOCK). A channel whose start key is held
// draws a new face value 1..FACES on every tick. A global finish level locks
// every channel, keeping its value. The sum of all dice is registered one cycle
// behind the dice values.
//
// Ports
//   clk      in   system clock (1 kHz nominal)
//   rst_n    in   asynchronous active-low reset
//   start    in   [N_CH]     per-channel roll request (level, debounced)
//   finish   in   1          global lock request (level)
//   dice     out  [N_CH*W]   packed die values, channel i at [i*W +: W]; 0 = never rolled
//   rolling  out  [N_CH]     channel is in ROLLING
//   held     out  [N_CH]     channel is in HELD
//   locked   out  1          finish lock active (registered finish)
//   tick     out  1          one-cycle pulse at each roll tick
//   clk_div  out  1          square wave toggling on every tick
//   sum      out  [W+clog2(N_CH+1)]  registered sum of all dice
// -----------------------------------------------------------------------------
module dice_roll_engine #(
    parameter int          N_CH     = 2,
    parameter int          W        = 4,
    parameter int          FACES    = 6,
    parameter int          TICK_DIV = 200,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CH-1:0]                 start,
    input  logic                            finish,
    output logic [N_CH*W-1:0]               dice,
    output logic [N_CH-1:0]                 rolling,
    output logic [N_CH-1:0]                 held,
    output logic                            locked,
    output logic                            tick,
    output logic                            clk_div,
    output logic [W+$clog2(N_CH+1)-1:0]     sum
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam int             SW       = W + $clog2(N_CH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_HELD = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    // Per-channel seed; an all-zero seed would freeze the LFSR, so it is
    // replaced with 1.
    function automatic logic [15:0] seed_of(input int ch);
        logic [15:0] s;
        s = SEED ^ 16'(ch * 32'h0000_1F35);
        if (s == 16'h0000) begin
            s = 16'h0001;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // One shift of the Fibonacci LFSR (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Map the low LFSR byte onto a face value 1..FACES.
    function automatic logic [W-1:0] draw(input logic [15:0] l);
        logic [7:0] r;
        r = (l[7:0] % 8'(FACES)) + 8'd1;
        return W'(r);
    endfunction

    logic [CW-1:0]              cnt_r;
    logic [CW-1:0]              cnt_nxt_s;
    logic                       tick_r;
    logic                       clk_div_r;
    logic                       locked_r;
    logic [N_CH-1:0][15:0]      lfsr_r;
    logic [N_CH-1:0][W-1:0]     dice_r;
    logic [N_CH-1:0][W-1:0]     dice_nxt_s;
    state_t                     state_r     [N_CH];
    state_t                     state_nxt_s [N_CH];
    logic [N_CH-1:0]            rolling_r;
    logic [N_CH-1:0]            held_r;
    logic [SW-1:0]              sum_r;
    logic [SW-1:0]              sum_s;

    // Prescaler next count: wraps from TICK_DIV-1 straight to 0.
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Per-channel next state and next die value; finish overrides everything,
    // including a tick arriving on the same edge.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            dice_nxt_s[i]  = dice_r[i];
            if (finish) begin
                state_nxt_s[i] = ST_LOCK;
            end else begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (start[i]) begin
                            state_nxt_s[i] = ST_ROLL;
                        end else begin
                            state_nxt_s[i] = ST_IDLE;
                        end
                    end
                    ST_ROLL: begin
                        // The draw uses the LFSR value before this edge's shift.
                        if (tick_r) begin
                            dice_nxt_s[i] = draw(lfsr_r[i]);
                        end else begin
                            dice_nxt_s[i] = dice_r[i];
                        end
                        if (!start[i]) begin
                            state_nxt_s[i] = ST_HELD;
                        end else begin
                            state_nxt_s[i] = ST_ROLL;
                        end
                    end
                    ST_HELD: begin
                        if (start[i]) begin
                            state_nxt_s[i] = ST_ROLL;
                        end else begin
                            state_nxt_s[i] = ST_HELD;
                        end
                    end
                    ST_LOCK: begin
                        // A channel that never drew a value returns to IDLE.
                        if (dice_r[i] != '0) begin
                            state_nxt_s[i] = ST_HELD;
                        end else begin
                            state_nxt_s[i] = ST_IDLE;
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Combinational sum of the currently registered dice values.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum_s = sum_s + SW'(dice_r[i]);
        end
    end

    // Prescaler, tick pulse, divided clock, lock flag and registered sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            tick_r    <= 1'b0;
            clk_div_r <= 1'b0;
            locked_r  <= 1'b0;
            sum_r     <= '0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            tick_r    <= (cnt_nxt_s == CNT_LAST);
            if (tick_r) begin
                clk_div_r <= ~clk_div_r;
            end
            locked_r  <= finish;
            sum_r     <= sum_s;
        end
    end

    // Channel FSMs, LFSRs and die values with registered status decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                lfsr_r[i]    <= seed_of(i);
                dice_r[i]    <= '0;
                state_r[i]   <= ST_IDLE;
                rolling_r[i] <= 1'b0;
                held_r[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                lfsr_r[i]    <= lfsr_next(lfsr_r[i]);
                dice_r[i]    <= dice_nxt_s[i];
                state_r[i]   <= state_nxt_s[i];
                rolling_r[i] <= (state_nxt_s[i] == ST_ROLL);
                held_r[i]    <= (state_nxt_s[i] == ST_HELD);
            end
        end
    end

    assign dice    = dice_r;
    assign rolling = rolling_r;
    assign held    = held_r;
    assign locked  = locked_r;
    assign tick    = tick_r;
    assign clk_div = clk_div_r;
    assign sum     = sum_r;

endmodule

// File: tb/tb_dice_roll_engine.sv
// -----------------------------------------------------------------------------
// tb_dice_roll_engine
//
// Self-checking bench for dice_roll_engine. Instance A uses the default
// parameters (2 channels, 6 faces, TICK_DIV 200); instance B uses 4 channels,
// 15 faces and TICK_DIV 2 for a long statistical run. A behavioural model
// (per-channel flags, integer face values, LFSR sequence) predicts every output
// each cycle. A vector table plus hand-written sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_dice_roll_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       rst_a_n;
    logic [1:0] start_a;
    logic       finish_a;
    logic [7:0] dice_a;
    logic [1:0] rolling_a, held_a;
    logic       locked_a, tick_a, clkdiv_a;
    logic [5:0] sum_a;

    // Instance B signals
    logic        rst_b_n;
    logic [3:0]  start_b;
    logic        finish_b;
    logic [15:0] dice_b;
    logic [3:0]  rolling_b, held_b;
    logic        locked_b, tick_b, clkdiv_b;
    logic [6:0]  sum_b;

    dice_roll_engine #(.N_CH(2), .W(4), .FACES(6), .TICK_DIV(200)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .start(start_a), .finish(finish_a),
        .dice(dice_a), .rolling(rolling_a), .held(held_a), .locked(locked_a),
        .tick(tick_a), .clk_div(clkdiv_a), .sum(sum_a)
    );

    dice_roll_engine #(.N_CH(4), .W(4), .FACES(15), .TICK_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .finish(finish_b),
        .dice(dice_b), .rolling(rolling_b), .held(held_b), .locked(locked_b),
        .tick(tick_b), .clk_div(clkdiv_b), .sum(sum_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int          phase;
    int          m_nch, m_faces, m_td;
    logic [15:0] m_lfsr [8];
    int          m_val  [8];
    bit          m_roll [8];
    bit          m_held [8];
    bit          m_lock [8];
    int          m_cnt;
    bit          m_clkdiv;
    int          m_sum;
    bit          m_locked;
    bit          m_drew0;

    bit          capture;
    bit          seq_cmp;
    int          seq_k;
    int          seq1 [$];
    bit          seen [16];
    int          max_sum;

    logic [7:0]  cur_st;
    logic        cur_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < m_nch; i++) begin
            logic [15:0] s;
            s = 16'hACE1 ^ 16'(i * 32'h1F35);
            if (s == 16'h0000) s = 16'h0001;
            m_lfsr[i] = s;
            m_val[i]  = 0;
            m_roll[i] = 1'b0;
            m_held[i] = 1'b0;
            m_lock[i] = 1'b0;
        end
        m_cnt    = 0;
        m_clkdiv = 1'b0;
        m_sum    = 0;
        m_locked = 1'b0;
        m_drew0  = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] st, input logic fin);
        bit t;
        int ns;
        t  = (m_cnt == m_td - 1);
        ns = 0;
        for (int i = 0; i < m_nch; i++) ns += m_val[i];
        m_drew0 = 1'b0;
        for (int i = 0; i < m_nch; i++) begin
            if (fin) begin
                m_lock[i] = 1'b1; m_roll[i] = 1'b0; m_held[i] = 1'b0;
            end else if (m_lock[i]) begin
                m_lock[i] = 1'b0;
                m_held[i] = (m_val[i] != 0);
            end else if (m_roll[i]) begin
                if (t) begin
                    m_val[i] = (int'(m_lfsr[i][7:0]) % m_faces) + 1;
                    if (i == 0) m_drew0 = 1'b1;
                end
                if (!st[i]) begin
                    m_roll[i] = 1'b0; m_held[i] = 1'b1;
                end
            end else if (m_held[i]) begin
                if (st[i]) begin
                    m_held[i] = 1'b0; m_roll[i] = 1'b1;
                end
            end else if (st[i]) begin
                m_roll[i] = 1'b1;
            end
            m_lfsr[i] = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
        end
        m_cnt = t ? 0 : m_cnt + 1;
        if (t) m_clkdiv = !m_clkdiv;
        m_sum    = ns;
        m_locked = fin;
        if (capture && m_drew0) seq1.push_back(m_val[0]);
    endtask

    function automatic logic [31:0] model_dice();
        logic [31:0] ed;
        ed = 32'd0;
        for (int i = 0; i < m_nch; i++) ed = ed | (32'(m_val[i]) << (4 * i));
        return ed;
    endfunction

    task automatic check_all();
        logic [31:0] d, ro, he, lk, tk, cd, sm, er, eh;
        er = 32'd0; eh = 32'd0;
        for (int i = 0; i < m_nch; i++) begin
            er[i] = m_roll[i];
            eh[i] = m_held[i];
        end
        if (phase == 0) begin
            d = 32'(dice_a); ro = 32'(rolling_a); he = 32'(held_a); lk = 32'(locked_a);
            tk = 32'(tick_a); cd = 32'(clkdiv_a); sm = 32'(sum_a);
        end else begin
            d = 32'(dice_b); ro = 32'(rolling_b); he = 32'(held_b); lk = 32'(locked_b);
            tk = 32'(tick_b); cd = 32'(clkdiv_b); sm = 32'(sum_b);
        end
        chk("dice",    d,  model_dice());
        chk("rolling", ro, er);
        chk("held",    he, eh);
        chk("locked",  lk, 32'(m_locked));
        chk("tick",    tk, 32'(m_cnt == m_td - 1));
        chk("clk_div", cd, 32'(m_clkdiv));
        chk("sum",     sm, 32'(m_sum));
        if (phase == 1) begin
            for (int i = 0; i < 4; i++) seen[(d >> (4 * i)) & 32'hF] = 1'b1;
            if (int'(sm) > max_sum) max_sum = int'(sm);
        end
        if (seq_cmp && m_drew0 && seq_k < seq1.size()) begin
            chk("reseed_seq", 32'(d[3:0]), 32'(seq1[seq_k]));
            seq_k++;
        end
    endtask

    task automatic drive();
        if (phase == 0) begin
            start_a  = cur_st[1:0];
            finish_a = cur_fin;
        end else begin
            start_b  = cur_st[3:0];
            finish_b = cur_fin;
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge(cur_st, cur_fin);
        #1;
        check_all();
    endtask

    // Advance until instance A shows tick high in the current cycle.
    task automatic wait_tick(input int max_cyc);
        int k;
        k = 0;
        while (tick_a !== 1'b1 && k < max_cyc) begin
            step();
            k++;
        end
        if (tick_a !== 1'b1) chk("tick_timeout", 32'(tick_a), 32'd1);
    endtask

    typedef struct {
        logic [1:0] st;
        logic       fin;
        int         ncyc;
        logic [1:0] exp_roll;
        logic [1:0] exp_held;
        logic       exp_lock;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] saved;

        tbl[0] = '{2'b00, 1'b0,    5, 2'b00, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1000, 2'b01, 2'b00, 1'b0};
        tbl[2] = '{2'b11, 1'b0,  250, 2'b11, 2'b00, 1'b0};
        tbl[3] = '{2'b01, 1'b0,    1, 2'b01, 2'b10, 1'b0};
        tbl[4] = '{2'b01, 1'b0,  450, 2'b01, 2'b10, 1'b0};
        tbl[5] = '{2'b00, 1'b0,    3, 2'b00, 2'b11, 1'b0};
        tbl[6] = '{2'b11, 1'b1,    3, 2'b00, 2'b00, 1'b1};
        tbl[7] = '{2'b00, 1'b0,    2, 2'b00, 2'b11, 1'b0};
        tbl[8] = '{2'b10, 1'b0,    1, 2'b10, 2'b01, 1'b0};

        phase = 0; capture = 1'b0; seq_cmp = 1'b0; seq_k = 0; max_sum = 0;
        for (int f = 0; f < 16; f++) seen[f] = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        start_a = 2'b00; finish_a = 1'b0; start_b = 4'h0; finish_b = 1'b0;
        cur_st = 8'h00; cur_fin = 1'b0;
        m_nch = 2; m_faces = 6; m_td = 200;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_a_n = 1'b1;

        // Vector table; draws of channel 0 in the first records are recorded
        // for the reseed comparison after the second reset.
        capture = 1'b1;
        for (int r = 0; r < 9; r++) begin
            cur_st  = 8'(tbl[r].st);
            cur_fin = tbl[r].fin;
            for (int n = 0; n < tbl[r].ncyc; n++) step();
            if (r == 1) capture = 1'b0;
            chk("tbl_rolling", 32'(rolling_a), 32'(tbl[r].exp_roll));
            chk("tbl_held",    32'(held_a),    32'(tbl[r].exp_held));
            chk("tbl_locked",  32'(locked_a),  32'(tbl[r].exp_lock));
        end

        // finish in the same cycle as tick while both channels roll
        cur_st = 8'h03; cur_fin = 1'b0;
        step();
        wait_tick(450);
        saved   = model_dice();
        cur_fin = 1'b1;
        step();
        chk("fin_tick_no_draw", 32'(dice_a), saved);
        chk("fin_tick_locked",  32'(locked_a), 32'd1);
        cur_st = 8'h00; step();
        cur_st = 8'h01; step();
        cur_st = 8'h02; step();
        chk("lock_ignore_start_roll", 32'(rolling_a), 32'd0);
        chk("lock_ignore_start_held", 32'(held_a), 32'd0);
        cur_fin = 1'b0; cur_st = 8'h00;
        step();
        chk("unlock_to_held", 32'(held_a), 32'd3);

        // start rise on a tick: enters ROLLING without drawing
        wait_tick(450);
        saved  = model_dice();
        cur_st = 8'h01;
        step();
        chk("rise_on_tick_rolling", 32'(rolling_a), 32'd1);
        chk("rise_on_tick_no_draw", 32'(dice_a), saved);
        step();
        // start fall on a tick: draw still happens, then HELD
        wait_tick(450);
        cur_st = 8'h00;
        step();
        chk("fall_on_tick_held", 32'(held_a), 32'd3);
        chk("fall_on_tick_draw", 32'(dice_a[3:0]), 32'(m_val[0]));

        // Asynchronous reset mid-period while rolling
        cur_st = 8'h03;
        repeat (50) step();
        #2;
        rst_a_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        cur_st  = 8'h00;
        start_a = 2'b00;
        rst_a_n = 1'b1;
        seq_cmp = 1'b1; seq_k = 0;
        repeat (5) step();
        cur_st = 8'h01;
        repeat (1000) step();
        seq_cmp = 1'b0;
        chk("reseed_draw_count", 32'(seq_k), 32'(seq1.size()));

        // Channel 1 never rolled: LOCK returns it to IDLE
        cur_fin = 1'b1;
        step(); step();
        cur_fin = 1'b0; cur_st = 8'h00;
        step();
        chk("never_rolled_held",   32'(held_a), 32'd1);
        chk("never_rolled_rolling", 32'(rolling_a), 32'd0);
        chk("never_rolled_value",  32'(dice_a[7:4]), 32'd0);

        // Randomised start/finish activity
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) cur_st[$urandom_range(0, 1)] = ~cur_st[$urandom_range(0, 1)];
            if ($urandom_range(0, 149) == 0) cur_fin = ~cur_fin;
            step();
        end
        cur_fin = 1'b0;
        cur_st  = 8'h00;
        drive();

        // Instance B: 4 channels, 15 faces, 10000 ticks
        phase = 1;
        m_nch = 4; m_faces = 15; m_td = 2;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        check_all();
        rst_b_n = 1'b1;
        cur_st  = 8'h0F;
        repeat (20000) step();
        for (int f = 1; f < 16; f++) chk("face_seen", 32'(seen[f]), 32'd1);
        chk("sum_max_le_60", 32'(max_sum <= 60), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dice_roll_engine.md
# dice_roll_engine

Parametrised multi-channel dice roller: a shared prescaler produces a roll tick every `TICK_DIV` clocks. On each tick, every channel whose start key is held draws a new face value (1..`FACES`) from its own free-running LFSR. A global `finish` freezes all channels. The block sits between the debounced player keys and the score/display logic, and provides per-channel status plus a registered sum of all dice.

## Interface
- `N_CH`, default 2: number of dice channels (1..8).
- `W`, default 4: bits per die value; `FACES` must be ≤ 2^`W`−1.
- `FACES`, default 6: faces per die (2..15); valid values are 1..`FACES`.
- `TICK_DIV`, default 200: clocks per roll tick (0.2 s at 1 kHz); ≥ 2.
- `SEED`, default 16'hACE1: base LFSR seed; channel i seed = `SEED` ^ (i*16'h1F35); a zero result is forced to 16'h0001.

Ports:
- `clk` in 1: system clock (1 kHz nominal).
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in `N_CH`: per-channel roll request, level, already debounced; bit i controls channel i.
- `finish` in 1: level; while high, all channels are locked.
- `dice` out `N_CH`*`W`: packed die values; channel i in bits [i*W +: W]; 0 means never rolled.
- `rolling` out `N_CH`: channel in ROLLING.
- `held` out `N_CH`: channel in HELD (value valid, not changing).
- `locked` out 1: `finish` lock active.
- `tick` out 1: one-cycle pulse at each roll tick.
- `clk_div` out 1: square wave that toggles on every tick.
- `sum` out `W`+clog2(`N_CH`+1): registered sum of all channel values.

## Operation
- Prescaler runs 0..`TICK_DIV`−1 and wraps. `tick`=1 while the count equals `TICK_DIV`−1. It runs in every state, including while locked.
- Each channel has a 16-bit Fibonacci LFSR. It advances every clock, shifting left with feedback l[15]^l[13]^l[12]^l[10]. It never holds 0.
- Draw on a tick: value = (lfsr[7:0] mod `FACES`) + 1, using the LFSR contents before that edge's shift.
- Per-channel FSM, all channels identical and independent:
  - IDLE (dice=0): `start`=1 and `finish`=0 → ROLLING.
  - ROLLING: on each tick, dice ← draw. `start`=0 → HELD.
  - HELD: value frozen. `start`=1 → ROLLING.
  - Any state with `finish`=1 → LOCK. The value is kept, and a tick on the same edge is ignored (finish has priority).
  - LOCK: `finish`=0 → HELD if the value ≠ 0, else IDLE. `start` is ignored while in LOCK.
- `rolling`/`held` decode ROLLING/HELD. `locked` = any channel in LOCK, which equals registered `finish`.
- `sum` = Σ dice, registered one cycle after `dice`. No overflow is possible at the specified width.

## Timing
- Reset (async assert, sync deassert by the user):
  - Outputs: `dice`=0, `sum`=0, `rolling`=0, `held`=0, `locked`=0, `tick`=0, `clk_div`=0.
  - Internal: prescaler=0, all FSMs in IDLE, LFSRs at their seeds.
- First tick is high in the cycle where the prescaler reaches `TICK_DIV`−1, i.e. cycle `TICK_DIV`−1 after reset release.
- State transitions take effect one clock after the input is sampled.
- `dice` changes on the edge that ends the `tick` cycle, so it is visible the cycle after `tick`. `sum` follows one cycle later. `clk_div` toggles on the same edge as `dice`.
- Edge cases:
  - A `start` rise in the same cycle as `tick`: the channel enters ROLLING on that edge and does not draw; the first draw is on the next tick.
  - A `start` fall in the same cycle as `tick`: the tick draw still occurs, then the channel enters HELD.
  - Prescaler wrap: count goes `TICK_DIV`−1 → 0 with no dead cycle.
  - Reset mid-roll clears everything immediately, without waiting for a clock.

## Test plan
- Reset, `TICK_DIV`=200, idle → `tick` pulses at cycles 199, 399, …; `clk_div` period 400; `dice`=0; `sum`=0; `rolling`=0.
- `start`=2'b01 held for 1000 cycles → channel 0 updates after each tick (5 draws); every value is in 1..6; channel 1 stays 0; `sum` equals the channel 0 value one cycle after each update.
- Both starts high, release `start[1]` mid-period → `held`=2'b10 next cycle; channel 1 value is constant across later ticks; channel 0 keeps updating.
- `finish` asserted in the same cycle as `tick` while both channels are ROLLING → no update on that edge; `locked`=1; `start` toggles are ignored. On `finish` drop, a channel with a value goes to HELD and a channel never rolled goes to IDLE.
- Assert `rst_n`=0 asynchronously mid-period during ROLLING → all outputs are 0 before the next `clk` edge. After release, the LFSR draw sequence matches the sequence from the first reset (deterministic seeds).
- `N_CH`=4, `FACES`=15, `W`=4, 10000 ticks on all channels → all values are in 1..15, each face appears, and `sum` ≤ 60 with width 7.
